// File: rtl/dota_pkg.sv
// Shared types and default configuration for the digital-OTA channel sequencer.
package dota_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_SETTLE_CYC = 3;
  localparam int DEF_VOTE_LEN   = 5;

  // Width of the settle/sample cycle counter and of the ones counter.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT
  } state_e;

  // Strict majority: more ones than half of an odd window.
  function automatic logic vote_win(input logic [CNT_W:0] ones,
                                    input int unsigned vote_len);
    return ones > 5'(vote_len >> 1);
  endfunction

endpackage

// File: rtl/dota_rr_pick.sv
// Round-robin channel search: first set mask bit strictly after 'last',
// wrapping NUM_CH-1 -> 0. Purely combinational.
module dota_rr_pick #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         mask,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic [$clog2(NUM_CH)-1:0] next,
  output logic                      found
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    next = last;
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(last) + i) % NUM_CH);
      if (mask[cand]) next = cand;
    end
  end

  assign found = |mask;

endmodule

// File: rtl/dota_seq_ctrl.sv
// Time-multiplexes one digital OTA across NUM_CH input pairs.
// Optional macro DOTA_MAJORITY_EN: VOTE_LEN-sample majority vote instead of a single sample.
module dota_seq_ctrl
  import dota_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int VOTE_LEN   = DEF_VOTE_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      ota_out,
  output logic [$clog2(NUM_CH)-1:0] ota_sel,
  output logic                      ota_hold,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic                      res_bit,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);

`ifdef DOTA_MAJORITY_EN
  localparam int SAMPLE_LEN = VOTE_LEN;
`else
  localparam int SAMPLE_LEN = 1;
`endif

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_LEN - 1);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("dota_seq_ctrl: NUM_CH must be in 2..8");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("dota_seq_ctrl: SETTLE_CYC must be in 1..15");
  end
  if (VOTE_LEN < 1 || VOTE_LEN > 15) begin : g_bad_vote_range
    $error("dota_seq_ctrl: VOTE_LEN must be in 1..15");
  end
`ifdef DOTA_MAJORITY_EN
  if ((VOTE_LEN % 2) == 0) begin : g_bad_vote_even
    $error("dota_seq_ctrl: VOTE_LEN must be odd");
  end
`endif

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cyc_q;
  logic [CH_W-1:0]  sel_q;
  logic [CH_W-1:0]  last_q;
  logic [CH_W-1:0]  pick_ch;
  logic             pick_found;
  logic             res_bit_q;
  logic             settle_done;
  logic             sample_done;
`ifdef DOTA_MAJORITY_EN
  logic [CNT_W-1:0] ones_q;
`endif

  assign settle_done = (cyc_q == SETTLE_LAST);
  assign sample_done = (cyc_q == SAMPLE_LAST);

  dota_rr_pick #(
    .NUM_CH(NUM_CH)
  ) u_rr_pick (
    .mask (ch_mask),
    .last (last_q),
    .next (pick_ch),
    .found(pick_found)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (en && pick_found) state_d = ST_SELECT;
      ST_SELECT: state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_SAMPLE;
      ST_SAMPLE: if (sample_done) state_d = ST_REPORT;
      ST_REPORT: if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Channel select, cycle counting and the decision register. en and ch_mask
  // only matter in IDLE, so a running conversion cannot be disturbed by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      sel_q     <= '0;
      last_q    <= CH_W'(NUM_CH - 1);
      res_bit_q <= 1'b0;
`ifdef DOTA_MAJORITY_EN
      ones_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          cyc_q <= '0;
`ifdef DOTA_MAJORITY_EN
          ones_q <= '0;
`endif
          if (en && pick_found) sel_q <= pick_ch;
        end
        ST_SETTLE: begin
          cyc_q <= settle_done ? '0 : cyc_q + CNT_W'(1);
        end
        ST_SAMPLE: begin
          cyc_q <= sample_done ? '0 : cyc_q + CNT_W'(1);
`ifdef DOTA_MAJORITY_EN
          ones_q <= ones_q + CNT_W'(ota_out);
          // Include the current cycle's sample in the final vote.
          if (sample_done)
            res_bit_q <= vote_win({1'b0, ones_q} + 5'(ota_out), VOTE_LEN);
`else
          res_bit_q <= ota_out;
`endif
        end
        ST_REPORT: begin
          if (res_ready) last_q <= sel_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ota_hold  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE:   busy      = 1'b0;
      ST_SELECT: ota_hold  = 1'b1;
      ST_REPORT: res_valid = 1'b1;
      default: ;
    endcase
  end

  assign ota_sel = sel_q;
  assign res_ch  = sel_q;
  assign res_bit = res_bit_q;

endmodule

// File: tb/tb_dota_seq_ctrl.sv
// Scoreboard bench for dota_seq_ctrl; expected channel/decision/latency are
// queued at launch and popped when res_valid rises.
module tb_dota_seq_ctrl;

  localparam int NUM_CH     = 4;
  localparam int SETTLE_CYC = 3;
  localparam int VOTE_LEN   = 5;
`ifdef DOTA_MAJORITY_EN
  localparam int V_EFF = VOTE_LEN;
`else
  localparam int V_EFF = 1;
`endif
  localparam int LAT    = 2 + SETTLE_CYC + V_EFF;
  localparam int BUDGET = 40;

  typedef struct {
    int   ch;
    logic res;
    int   lat;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic [NUM_CH-1:0]         ch_mask;
  logic                      ota_out;
  logic [$clog2(NUM_CH)-1:0] ota_sel;
  logic                      ota_hold;
  logic                      res_valid;
  logic                      res_ready;
  logic [$clog2(NUM_CH)-1:0] res_ch;
  logic                      res_bit;
  logic                      busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_served = NUM_CH - 1;
  exp_t sb[$];

  always #5 clk = ~clk;

  dota_seq_ctrl #(
    .NUM_CH    (NUM_CH),
    .SETTLE_CYC(SETTLE_CYC),
    .VOTE_LEN  (VOTE_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_mask  (ch_mask),
    .ota_out  (ota_out),
    .ota_sel  (ota_sel),
    .ota_hold (ota_hold),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_ch   (res_ch),
    .res_bit  (res_bit),
    .busy     (busy)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int rr_next(input logic [NUM_CH-1:0] m, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      int j = (last + k) % NUM_CH;
      if (((32'(m) >> j) & 32'd1) != 0) return j;
    end
    return -1;
  endfunction

  function automatic logic exp_bit(input logic [14:0] pat);
`ifdef DOTA_MAJORITY_EN
    int ones = 0;
    for (int k = 0; k < VOTE_LEN; k++) ones += int'((pat >> k) & 15'd1);
    return ones > VOTE_LEN / 2;
`else
    return pat[0];
`endif
  endfunction

  function automatic logic pat_bit(input logic [14:0] pat, input int k);
    logic [14:0] sh;
    sh = pat >> k;
    return sh[0];
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, ".busy"},      int'(busy),      0);
    check({tag, ".res_valid"}, int'(res_valid), 0);
    check({tag, ".ota_hold"},  int'(ota_hold),  0);
    check({tag, ".ota_sel"},   int'(ota_sel),   0);
    check({tag, ".res_ch"},    int'(res_ch),    0);
    check({tag, ".res_bit"},   int'(res_bit),   0);
  endtask

  // One conversion launched from IDLE. Called and returning at a negedge.
  task automatic run_conv(input logic [NUM_CH-1:0] m, input logic [14:0] settle_pat,
                          input logic [14:0] samp_pat, input int ready_dly,
                          input int abort_cyc, input string tag);
    exp_t e;
    int   holds = 0;
    int   busy_low = 0;
    int   lat = 0;
    int   bad = 0;
    int   k;
    bit   seen = 0;
    bit   aborted = 0;
    e.ch  = rr_next(m, last_served);
    e.res = exp_bit(samp_pat);
    e.lat = LAT;
    sb.push_back(e);
    en = 1'b1;
    ch_mask = m;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(posedge clk); #1;
      if (cyc == abort_cyc) begin
        aborted = 1;
        break;
      end
      // Inputs wander after the pick; the conversion must ignore them.
      if (cyc == 1) begin
        en = 1'b0;
        ch_mask = '0;
      end else begin
        en = 1'($urandom_range(0, 1));
        ch_mask = NUM_CH'($urandom);
      end
      k = cyc - (2 + SETTLE_CYC);
      if (cyc >= 2 && cyc < 2 + SETTLE_CYC) ota_out = pat_bit(settle_pat, cyc - 2);
      else if (k >= 0 && k < V_EFF)         ota_out = pat_bit(samp_pat, k);
      else                                  ota_out = 1'($urandom);
      @(negedge clk);
      if (ota_hold) holds++;
      if (!busy) busy_low++;
      if (cyc == 2) check({tag, ".sel_settle"}, int'(ota_sel), e.ch);
      if (res_valid) begin
        seen = 1;
        lat = cyc;
        break;
      end
    end
    en = 1'b0;
    if (aborted) begin
      en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      reset_checks({tag, ".rst"});
      void'(sb.pop_front());
      last_served = NUM_CH - 1;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (res_valid || busy) bad++;
      end
      check({tag, ".no_valid_after_rst"}, bad, 0);
      return;
    end
    if (!seen) begin
      check({tag, ".timeout"}, 0, 1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check({tag, ".lat"},   lat,            e.lat);
    check({tag, ".ch"},    int'(res_ch),   e.ch);
    check({tag, ".bit"},   int'(res_bit),  int'(e.res));
    check({tag, ".sel"},   int'(ota_sel),  e.ch);
    check({tag, ".holds"}, holds,          1);
    check({tag, ".busy"},  busy_low,       0);
    for (int d = 0; d < ready_dly; d++) begin
      if (d % 2 == 0) en = 1'b1;
      else            en = 1'b0;
      ch_mask = NUM_CH'($urandom);
      @(negedge clk);
      if (!res_valid || int'(res_ch) != e.ch || res_bit !== e.res ||
          ota_hold || int'(ota_sel) != e.ch || !busy) bad++;
    end
    if (ready_dly > 0) check({tag, ".stall_stable"}, bad, 0);
    en = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({tag, ".done"}, int'({res_valid, busy}), 0);
    last_served = e.ch;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    ch_mask = '0;
    ota_out = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    // No conversion without both en and a nonzero mask.
    en = 1'b1; ch_mask = '0;
    repeat (3) @(negedge clk);
    check("idle.mask0", int'(busy), 0);
    en = 1'b0; ch_mask = '1;
    repeat (3) @(negedge clk);
    check("idle.en0", int'(busy), 0);
    ch_mask = '0;

    // Round robin across all channels, starting at channel 0.
    for (int i = 0; i < 5; i++) run_conv(4'b1111, 15'h0000, 15'h7fff, 0, 0, "rr_all");
    // Sparse mask: only channels 1 and 3.
    for (int i = 0; i < 4; i++) run_conv(4'b1010, 15'h0000, 15'h7fff, 0, 0, "rr_1010");

    // Decision patterns, with settle-window noise that must not matter.
    run_conv(4'b1111, 15'h5555, 15'b000_0000_0000_0101, 0, 0, "vote_10100");
    run_conv(4'b1111, 15'h2aaa, 15'b000_0000_0001_0011, 0, 0, "vote_11001");
    run_conv(4'b1111, 15'h7fff, 15'b000_0000_0000_0000, 0, 0, "vote_settle1");
    run_conv(4'b1111, 15'h0000, 15'b000_0000_0001_1110, 0, 0, "vote_01111");

    // Consumer stalls for 7 cycles.
    run_conv(4'b1111, 15'h0000, 15'h7fff, 7, 0, "stall");

    // Reset mid-sample, then channel 0 must come next.
    run_conv(4'b1111, 15'h0000, 15'h7fff, 0, 2 + SETTLE_CYC + V_EFF / 2, "abort");
    run_conv(4'b1111, 15'h0000, 15'h7fff, 0, 0, "post_rst");
    check("post_rst.sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dota_seq_ctrl.md
DOTA_SEQ_CTRL -- requirements
Module: dota_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of differential input pairs sharing one digital OTA; legal range 2..8.
REQ-002 SHALL have parameter SETTLE_CYC, default 3: cycles discarded after each channel switch; legal range 1..15.
REQ-003 SHALL have parameter VOTE_LEN, default 5: OTA output samples per decision; odd, 1..15; an even value is an elaboration error.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  permit new conversions.
- ch_mask  in  NUM_CH  per-channel enable; bit i = 1 makes channel i eligible.
- ota_out  in  1  digital OTA comparator output.
- ota_sel  out  clog2(NUM_CH)  input-pair mux select for the OTA.
- ota_hold  out  1  forces the OTA into hold/reset while the mux switches.
- res_valid  out  1  decision available.
- res_ready  in  1  consumer accepts the decision.
- res_ch  out  clog2(NUM_CH)  channel of the decision.
- res_bit  out  1  decision: 1 means Vip > Vin.
- busy  out  1  conversion in progress.

Function
REQ-005 SHALL implement states IDLE, SELECT, SETTLE, SAMPLE and REPORT; busy SHALL be 1 in every state except IDLE.
REQ-006 IDLE: if en=1 and ch_mask!=0, SHALL pick the first set ch_mask bit after the last-served channel (round-robin, wrapping NUM_CH-1 -> 0) and go to SELECT; otherwise stay in IDLE.
REQ-007 SELECT: one cycle; SHALL register the picked channel onto ota_sel and res_ch, drive ota_hold=1, then go to SETTLE.
REQ-008 SETTLE: exactly SETTLE_CYC cycles; ota_hold=0; ota_out SHALL be ignored; then go to SAMPLE.
REQ-009 SAMPLE: exactly VOTE_LEN cycles; SHALL count the cycles with ota_out=1 in a 4-bit counter, then go to REPORT.
REQ-010 REPORT: res_valid=1; res_bit = (ones count > VOTE_LEN/2); res_bit and res_ch SHALL stay stable while res_valid=1 and res_ready=0.
REQ-011 On res_valid and res_ready both 1, SHALL deassert res_valid the next cycle, record res_ch as last-served, and return to IDLE.
REQ-012 Latency: for a pick in IDLE at cycle N, res_valid SHALL first rise at cycle N+2+SETTLE_CYC+VOTE_LEN (N+10 with defaults).
REQ-013 en or ch_mask changes after leaving IDLE SHALL NOT abort the conversion; both SHALL be sampled only in IDLE.
REQ-014 ota_sel SHALL change only on the SELECT edge; ota_hold SHALL be 0 in all states except SELECT.

Reset
REQ-015 With rst=1 at a clock edge: state=IDLE, ota_sel=0, res_ch=0, ota_hold=0, res_valid=0, res_bit=0, busy=0, counters=0, last-served=NUM_CH-1, so that channel 0 is served first.
REQ-016 rst SHALL take priority over every other input in every state; a conversion in progress SHALL be discarded and no res_valid SHALL be produced for it.

Configuration
REQ-017 Macro DOTA_MAJORITY_EN: when defined, SAMPLE and voting SHALL follow REQ-009/010. When undefined, SAMPLE SHALL last one cycle, res_bit SHALL equal ota_out from that cycle, VOTE_LEN SHALL be ignored, and latency SHALL become N+3+SETTLE_CYC.

Structure
REQ-018 Package dota_pkg SHALL hold the state enum typedef and the default NUM_CH, SETTLE_CYC and VOTE_LEN constants.
REQ-019 The round-robin search SHALL be a combinational sub-module, dota_rr_pick, with inputs mask and last and outputs next and found.

Verification
REQ-020 Reset, en=1, mask=4'b1111, ota_out=1, res_ready=1 -> results for ch 0,1,2,3,0 in that order, each res_bit=1, first res_valid 10 cycles after leaving IDLE.
REQ-021 mask=4'b1010, alternating conversions -> only ch 1 and 3 served, alternating; ota_hold high exactly one cycle per conversion.
REQ-022 During SAMPLE ota_out=1,0,1,0,0 -> res_bit=0; with 1,1,0,0,1 -> res_bit=1; ota_out toggling during SETTLE has no effect on res_bit.
REQ-023 Hold res_ready=0 for 7 cycles in REPORT -> res_valid, res_ch and res_bit stable; no new SELECT until the handshake.
REQ-024 Assert rst in the middle of SAMPLE -> next cycle IDLE with all outputs at reset values; the next conversion serves ch 0.
REQ-025 Build without DOTA_MAJORITY_EN -> res_valid 6 cycles after the IDLE pick; res_bit equals the single sampled ota_out.
